// File: rtl/demux_dispatch3.sv
// demux_dispatch3: one-entry registered 1-to-3 dispatcher with sticky invalid-sel flag.
// Optional invalid-sel counter on err_cnt is built only when DEMUX_ERRCNT_EN is defined.
module demux_dispatch3 #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [Width-1:0] in_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  output logic [Width-1:0] a_data,
  output logic [Width-1:0] b_data,
  output logic [Width-1:0] c_data,
  output logic             err,
  output logic [7:0]       err_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic t_ready, accept, load, bad;
  // only the held target's ready matters; the others are masked by their zero valid
  assign t_ready  = (a_valid & a_ready) | (b_valid & b_ready) | (c_valid & c_ready);
  assign in_ready = rstn && (state == IDLE || t_ready);
  assign accept   = in_valid && in_ready;
  assign bad      = accept && in_sel == 2'b11;
  assign load     = accept && in_sel != 2'b11;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      c_valid <= 1'b0;
      a_data  <= '0;
      b_data  <= '0;
      c_data  <= '0;
      err     <= 1'b0;
    end else begin
      if (load) begin
        state   <= BUSY;
        a_valid <= in_sel == 2'b00;
        b_valid <= in_sel == 2'b01;
        c_valid <= in_sel == 2'b10;
        a_data  <= in_sel == 2'b00 ? in_data : '0;
        b_data  <= in_sel == 2'b01 ? in_data : '0;
        c_data  <= in_sel == 2'b10 ? in_data : '0;
      end else if (state == BUSY && t_ready) begin
        state   <= IDLE;
        a_valid <= 1'b0;
        b_valid <= 1'b0;
        c_valid <= 1'b0;
        a_data  <= '0;
        b_data  <= '0;
        c_data  <= '0;
      end
      if (bad) err <= 1'b1;
    end
  end
`ifdef DEMUX_ERRCNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_cnt <= 8'h00;
    else if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
  end
`else
  assign err_cnt = 8'h00;
`endif
endmodule
